// File: rtl/fft_frame_scheduler.sv
// Sequences one FFT frame: load input buffer, start core, wait, unload result, hold for consumer.
// Optional WAIT watchdog is built only when FFT_SCHED_TIMEOUT_EN is defined.
//
// state    | meaning
// S_IDLE   | no frame in flight, waiting for frame_valid
// S_LOAD   | streaming N_WORDS input words into the core
// S_START  | single-cycle core start, input buffer released
// S_WAIT   | core computing; done ignored on the first cycle
// S_UNLOAD | streaming N_WORDS results into the result buffer
// S_HOLD   | result buffer complete, waiting for result_ack
module fft_frame_scheduler #(
  parameter int N_WORDS        = 64,
  parameter int IDX_W          = 6,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic             fft_done,
  input  logic             result_ack,
  output logic [IDX_W-1:0] in_idx,
  output logic             fft_load,
  output logic             fft_start,
  output logic             frame_taken,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_we,
  output logic             result_ready,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD, S_HOLD
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  if ((2 ** IDX_W) < N_WORDS || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("fft_frame_scheduler: IDX_W too narrow or TIMEOUT_CYCLES < 1");
  end

  state_t state;
  logic   wait_first;

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  logic [TMR_W-1:0] wd_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      in_idx       <= '0;
      out_idx      <= '0;
      fft_load     <= 1'b0;
      fft_start    <= 1'b0;
      frame_taken  <= 1'b0;
      out_we       <= 1'b0;
      result_ready <= 1'b0;
      busy         <= 1'b0;
      wait_first   <= 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
      timeout      <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      fft_start   <= 1'b0;
      frame_taken <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_valid) begin
            state    <= S_LOAD;
            in_idx   <= '0;
            fft_load <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_idx == LAST_IDX) begin
            state       <= S_START;
            in_idx      <= '0;
            fft_load    <= 1'b0;
            fft_start   <= 1'b1;
            frame_taken <= 1'b1;
          end else begin
            in_idx <= in_idx + IDX_ONE;
          end
        end
        S_START: begin
          state      <= S_WAIT;
          wait_first <= 1'b1;
`ifdef FFT_SCHED_TIMEOUT_EN
          wd_cnt     <= TMR_LOAD;
`endif
        end
        S_WAIT: begin
          // done may still be high from the previous frame on the first cycle
          wait_first <= 1'b0;
          if (!wait_first && fft_done) begin
            state   <= S_UNLOAD;
            out_idx <= '0;
            out_we  <= 1'b1;
          end
`ifdef FFT_SCHED_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            state   <= S_IDLE;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt - TMR_ONE;
          end
`endif
        end
        S_UNLOAD: begin
          if (out_idx == LAST_IDX) begin
            state        <= S_HOLD;
            out_idx      <= '0;
            out_we       <= 1'b0;
            result_ready <= 1'b1;
          end else begin
            out_idx <= out_idx + IDX_ONE;
          end
        end
        S_HOLD: begin
          if (result_ack) begin
            state        <= S_IDLE;
            result_ready <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          in_idx       <= '0;
          out_idx      <= '0;
          fft_load     <= 1'b0;
          out_we       <= 1'b0;
          result_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized bench for fft_frame_scheduler against a phase/count reference model.
// Watchdog expectations follow FFT_SCHED_TIMEOUT_EN when the bench is built with it.
module tb_fft_frame_scheduler;

  localparam int NW = 64;
  localparam int IW = 6;
  localparam int TO = 16;

  localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_WAIT = 3, P_UNLOAD = 4, P_HOLD = 5;

  logic          clk = 1'b0;
  logic          reset, frame_valid, fft_done, result_ack;
  logic [IW-1:0] in_idx, out_idx;
  logic          fft_load, fft_start, frame_taken, out_we, result_ready, busy, timeout;

  fft_frame_scheduler #(.N_WORDS(NW), .IDX_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .fft_done(fft_done),
    .result_ack(result_ack), .in_idx(in_idx), .fft_load(fft_load), .fft_start(fft_start),
    .frame_taken(frame_taken), .out_idx(out_idx), .out_we(out_we),
    .result_ready(result_ready), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which phase of the frame we are in and how far into it.
  int m_ph   = P_IDLE;
  int m_cnt  = 0;
  int m_wait = 0;
  int m_hold = 0;
  bit m_to   = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t phase=%0d cnt=%0d)", tag, obs, exp, $time, m_ph, m_cnt);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_ph = P_IDLE; m_cnt = 0; m_to = 1'b0;
    end else begin
      case (m_ph)
        P_IDLE:  if (frame_valid) begin m_ph = P_LOAD; m_cnt = 0; end
        P_LOAD:  if (m_cnt == NW - 1) begin m_ph = P_START; m_cnt = 0; end else m_cnt++;
        P_START: begin m_ph = P_WAIT; m_wait = 0; end
        P_WAIT: begin
          m_wait++;
          if (fft_done && m_wait > 1) begin
            m_ph = P_UNLOAD; m_cnt = 0;
          end
`ifdef FFT_SCHED_TIMEOUT_EN
          else if (m_wait == TO) begin
            m_ph = P_IDLE; m_to = 1'b1;
          end
`endif
        end
        P_UNLOAD: if (m_cnt == NW - 1) begin m_ph = P_HOLD; m_cnt = 0; m_hold = 0; end else m_cnt++;
        P_HOLD:   if (result_ack) m_ph = P_IDLE; else m_hold++;
        default:  m_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic check_outputs();
    check_eq("in_idx",       int'(in_idx),       (m_ph == P_LOAD)   ? m_cnt : 0);
    check_eq("fft_load",     int'(fft_load),     int'(m_ph == P_LOAD));
    check_eq("fft_start",    int'(fft_start),    int'(m_ph == P_START));
    check_eq("frame_taken",  int'(frame_taken),  int'(m_ph == P_START));
    check_eq("out_idx",      int'(out_idx),      (m_ph == P_UNLOAD) ? m_cnt : 0);
    check_eq("out_we",       int'(out_we),       int'(m_ph == P_UNLOAD));
    check_eq("result_ready", int'(result_ready), int'(m_ph == P_HOLD));
    check_eq("busy",         int'(busy),         int'(m_ph != P_IDLE));
    check_eq("timeout",      int'(timeout),      int'(m_to));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    int  dly, ack_dly;
    bit  stale, noise, rst_mid_load, rst_done;

    reset = 1'b1; frame_valid = 1'b1; fft_done = 1'b0; result_ack = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;

    for (int run = 0; run < 20; run++) begin
      stale        = (run == 2);
      rst_mid_load = (run == 3);
      noise        = (run >= 5) && ($urandom_range(0, 1) == 1);
      rst_done     = 1'b0;
      case (run)
        0:       begin dly = 100; ack_dly = 0;  end
        1:       begin dly = 10;  ack_dly = 50; end
        4:       begin dly = 1;   ack_dly = 0;  end
        default: begin dly = int'($urandom_range(1, 20)); ack_dly = int'($urandom_range(0, 5)); end
      endcase

      for (int c = 0; c < 350; c++) begin
        reset = 1'b0;
        if (rst_mid_load && !rst_done && m_ph == P_LOAD && m_cnt == 30) begin
          reset = 1'b1; rst_done = 1'b1;
        end else if (noise && $urandom_range(0, 399) == 0) begin
          reset = 1'b1;
        end
        frame_valid = noise ? ($urandom_range(0, 1) == 1) : 1'b1;
        fft_done    = stale || (m_ph == P_WAIT && m_wait >= dly) ||
                      (noise && $urandom_range(0, 3) == 0);
        result_ack  = (m_ph == P_HOLD && m_hold >= ack_dly) ||
                      (noise && $urandom_range(0, 2) == 0);
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

Interface
REQ-001 Parameter N_WORDS, default 64: 32-bit words per FFT frame.
REQ-002 Parameter IDX_W, default 6: index width, SHALL satisfy 2**IDX_W >= N_WORDS.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: watchdog limit in WAIT, used only with FFT_SCHED_TIMEOUT_EN.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_valid  input  1  level; input frame buffer full.
REQ-007 fft_done  input  1  level; FFT core finished current frame.
REQ-008 result_ack  input  1  level; consumer has taken result buffer.
REQ-009 in_idx  output  IDX_W  input buffer word index, also FFT load address.
REQ-010 fft_load  output  1  FFT core load strobe, one word per cycle.
REQ-011 fft_start  output  1  one-cycle FFT start pulse.
REQ-012 frame_taken  output  1  one-cycle pulse; input buffer may be refilled.
REQ-013 out_idx  output  IDX_W  result buffer write index.
REQ-014 out_we  output  1  result buffer write enable.
REQ-015 result_ready  output  1  level; result buffer complete.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout  output  1  sticky watchdog flag; constant 0 without FFT_SCHED_TIMEOUT_EN.

Function
REQ-018 States: IDLE, LOAD, START, WAIT, UNLOAD, HOLD, held in registers; all outputs registered or decoded from state and counters only.
REQ-019 IDLE -> LOAD when frame_valid=1, sampled on a rising edge; in_idx=0 on entry.
REQ-020 LOAD: fft_load=1 each cycle; in_idx increments 0..N_WORDS-1, one per cycle; after N_WORDS cycles -> START.
REQ-021 frame_taken pulses for exactly one cycle, on the cycle START is entered.
REQ-022 START: fft_start=1 for exactly one cycle -> WAIT.
REQ-023 WAIT: fft_done ignored on the first WAIT cycle; thereafter fft_done=1 -> UNLOAD with out_idx=0.
REQ-024 UNLOAD: out_we=1 each cycle; out_idx increments 0..N_WORDS-1; after N_WORDS cycles -> HOLD.
REQ-025 HOLD: result_ready=1; result_ack=1 -> IDLE, and result_ready deasserts on the next cycle.
REQ-026 result_ack asserted on the first HOLD cycle is honoured; result_ack outside HOLD is ignored.
REQ-027 frame_valid outside IDLE is ignored and not latched; a frame still pending on return to IDLE starts LOAD on the following cycle.
REQ-028 Counters do not wrap: the terminal index is N_WORDS-1, then the counter clears to 0 on the state exit.
REQ-029 Latency: frame_valid to first fft_load = 1 cycle; LOAD to fft_start = N_WORDS+1 cycles.

Reset
REQ-030 reset=1 at a rising edge forces IDLE, in_idx=0, out_idx=0, and all 1-bit outputs to 0 (including timeout); reset takes priority over every transition.
REQ-031 Reset mid-LOAD, WAIT or UNLOAD aborts the frame without a frame_taken or result_ready pulse; operation resumes normally from IDLE.

Configuration
REQ-032 Macro FFT_SCHED_TIMEOUT_EN defined: a cycle counter runs in WAIT; if fft_done is not seen within TIMEOUT_CYCLES cycles, set timeout=1, go to IDLE, and skip UNLOAD and HOLD.
REQ-033 timeout stays set until reset; later frames still process normally.
REQ-034 Macro FFT_SCHED_TIMEOUT_EN undefined: no counter is built, WAIT lasts indefinitely, and timeout is tied to 0.

Verification
REQ-035 Nominal frame, N_WORDS=64: frame_valid=1, fft_done after 100 cycles, result_ack on the first HOLD cycle -> 64 fft_load cycles with in_idx 0..63, one frame_taken, one fft_start, 64 out_we cycles with out_idx 0..63, result_ready high for 1 cycle.
REQ-036 Back-pressure: result_ack withheld 50 cycles while frame_valid=1 -> result_ready high for 50+ cycles, no second LOAD until the cycle after ack.
REQ-037 Stale done: fft_done held 1 through START and the first WAIT cycle -> UNLOAD begins no earlier than the second WAIT cycle.
REQ-038 Reset at in_idx=30 during LOAD -> next cycle IDLE, all outputs 0, no frame_taken; a new frame completes normally.
REQ-039 FFT_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, fft_done never asserted -> timeout=1 after 16 WAIT cycles, return to IDLE, no out_we; the next frame with done completes while timeout stays 1.
REQ-040 Throughput: frame_valid held high with immediate acks -> consecutive frames restart LOAD exactly 1 cycle after each return to IDLE.
